// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input debouncer.
//   STABLE_CYCLES_DEFAULT : 10 ms at a 10 MHz clock
//   STABLE_CYCLES_SIM     : short stability window for simulation
//   clog2_u()             : ceil(log2(value)), used to size the counters
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 100000;
    localparam int unsigned STABLE_CYCLES_SIM     = 4;

    function automatic int unsigned clog2_u(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = clog2_u(STABLE_CYCLES_DEFAULT);

endpackage

// File: rtl/input_debouncer_if.sv
// Bundle between the switch bank and the debouncer.
//   raw_in     : asynchronous switch/button levels
//   clean_out  : debounced level per channel
//   rise_pulse : one-cycle pulse on a 0->1 change of clean_out
//   fall_pulse : one-cycle pulse on a 1->0 change of clean_out
//   any_change : high in the same cycle as any rise/fall pulse
// master = switch side (drives raw_in), slave = debouncer.
interface input_debouncer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;

    modport master (
        output raw_in,
        input  clean_out,
        input  rise_pulse,
        input  fall_pulse,
        input  any_change
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output rise_pulse,
        output fall_pulse,
        output any_change
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounced channel: 2-FF synchroniser, stability counter, clean level and edge pulses.
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : asynchronous input level
//   clean       : debounced level
//   rise, fall  : one-cycle pulses coincident with the first cycle of a new clean level
//   change_next : next-state of (rise | fall), lets the parent register any_change in step
module debounce_channel #(
    parameter int unsigned CNT_W         = 17,
    parameter int unsigned STABLE_CYCLES = 100000,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic change_next
);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any cycle where the synchronised input agrees with clean restarts the window.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != clean_q) begin
            if (cnt_q == LastCnt) begin
                clean_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign clean       = clean_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign change_next = rise_d | fall_d;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bank of WIDTH switch inputs for the counter control path.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input_debouncer_if slave (raw_in in; clean_out, rise_pulse,
//                fall_pulse, any_change out)
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned      CNT_W         = CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input_debouncer_if.slave   bus
);
    logic [WIDTH-1:0] clean_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] change_next_vec;
    logic             any_change_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (bus.raw_in[i]),
            .clean       (clean_vec[i]),
            .rise        (rise_vec[i]),
            .fall        (fall_vec[i]),
            .change_next (change_next_vec[i])
        );
    end

    // Built from the channels' next-state so it lands in the same cycle as the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |change_next_vec;
        end
    end

    assign bus.clean_out  = clean_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.fall_pulse = fall_vec;
    assign bus.any_change = any_change_q;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int unsigned S = STABLE_CYCLES_SIM;
    localparam logic [7:0]  RV = 8'h00;

    typedef struct packed {
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_debouncer_if #(.WIDTH(8)) bus ();

    input_debouncer #(
        .WIDTH         (8),
        .STABLE_CYCLES (S),
        .CNT_W         (3),
        .RESET_VAL     (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    logic [7:0] samp[$];   // raw values captured at each clock edge since reset
    logic [7:0] m_clean;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("clean_out", bus.clean_out, e.clean);
            check("rise_pulse", bus.rise_pulse, e.rise);
            check("fall_pulse", bus.fall_pulse, e.fall);
            check("any_change", {7'd0, bus.any_change}, {7'd0, e.any});
        end
    end

    task automatic model_reset();
        m_clean = RV;
        samp = {RV, RV};
    endtask

    // A channel follows the input once the S most recent synchronised samples
    // (each two edges old) all disagree with its current clean level.
    task automatic step(input logic [7:0] r);
        exp_t e;
        logic [7:0] v;
        bus.raw_in = r;
        @(posedge clk);
        e.rise = '0;
        e.fall = '0;
        if (!rst_n) begin
            e.clean = RV;
            e.any = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic ok;
                ok = (samp.size() >= S + 1);
                for (int j = 1; j <= int'(S) && ok; j++) begin
                    v = samp[samp.size() - 1 - j];
                    if (v[i] == m_clean[i]) ok = 1'b0;
                end
                if (ok) begin
                    if (m_clean[i]) e.fall[i] = 1'b1;
                    else            e.rise[i] = 1'b1;
                    m_clean[i] = ~m_clean[i];
                end
            end
            e.clean = m_clean;
            e.any = |(e.rise | e.fall);
            samp.push_back(r);
            if (samp.size() > S + 2) void'(samp.pop_front());
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] r, input int n);
        for (int k = 0; k < n; k++) step(r);
    endtask

    // Asynchronous reset pulse that lands entirely between two rising edges.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        model_reset();
        bus.raw_in = 8'hFF;

        // Reset held with all inputs high, then released.
        hold(8'hFF, 3);
        #1 rst_n = 1'b1;
        hold(8'hFF, 8);
        hold(8'h00, 8);

        // Clean press on bit 0.
        hold(8'h01, 8);

        // Bounce on bit 3 shorter than the stability window.
        hold(8'h09, 3);
        hold(8'h01, 1);
        hold(8'h09, 3);
        hold(8'h01, 8);

        // Release of bit 0.
        hold(8'h00, 8);

        // Several channels at once.
        hold(8'hA5, 8);
        hold(8'h00, 8);

        // Reset in the middle of a count.
        hold(8'h80, 4);
        reset_pulse();
        hold(8'h80, 8);

        // Randomised bouncing with occasional resets.
        r = 8'h80;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) r = r ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 199) == 0) reset_pulse();
            step(r);
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
